// File: rtl/viterbi_channel_sim.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_channel_sim
// Description : Bit-error channel model between a convolutional encoder and a
//               Viterbi decoder. Registers each coded symbol and flips
//               selected bits in one of four modes: off, LFSR-random, burst
//               or fixed-period. Saturating counters record symbols passed,
//               corrupted symbols and flipped bits.
//               Optional macro VITERBI_CHAN_INJ_ROTATE_EN: each trigger flips
//               a single lane, rotating through the set bits of lane_mask_i.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_channel_sim #(
    parameter int                SYM_W     = 2,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                CNT_W     = 16,
    parameter int                LEN_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [SYM_W-1:0]  sym_i,
    input  logic [1:0]        mode_i,
    input  logic [LFSR_W-1:0] thresh_i,
    input  logic [SYM_W-1:0]  lane_mask_i,
    input  logic [LEN_W-1:0]  burst_len_i,
    input  logic [LEN_W-1:0]  period_i,
    input  logic              clr_i,
    output logic              valid_o,
    output logic [SYM_W-1:0]  sym_o,
    output logic [SYM_W-1:0]  err_inj_o,
    output logic [CNT_W-1:0]  sym_ct_o,
    output logic [CNT_W-1:0]  inj_sym_ct_o,
    output logic [CNT_W-1:0]  inj_bit_ct_o,
    output logic              sat_o
);

    localparam logic [1:0] c_MODE_OFF    = 2'd0;
    localparam logic [1:0] c_MODE_RANDOM = 2'd1;
    localparam logic [1:0] c_MODE_BURST  = 2'd2;
    localparam logic [1:0] c_MODE_PERIOD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LFSR_W-1:0] r_lfsr;
    state_t            r_state;
    logic [LEN_W-1:0]  r_bcnt;
    logic [LEN_W-1:0]  r_pcnt;
    logic              r_valid;
    logic [SYM_W-1:0]  r_sym;
    logic [SYM_W-1:0]  r_err;
    logic [CNT_W-1:0]  r_sym_ct;
    logic [CNT_W-1:0]  r_inj_sym_ct;
    logic [CNT_W-1:0]  r_inj_bit_ct;
    logic              r_sat;

    // ------------------------------------------------------------------
    // Trigger decode
    // ------------------------------------------------------------------
    logic              w_rand_hit;
    logic [LEN_W-1:0]  w_len_eff;
    logic [LEN_W:0]    w_bcnt_inc;
    logic              w_b_last;
    logic [LEN_W:0]    w_pcnt_inc;
    logic              w_period_hit;
    logic              w_trig;
    logic [SYM_W-1:0]  w_flip;

    assign w_rand_hit   = (r_lfsr < thresh_i);
    // A zero burst length behaves as a length of one.
    assign w_len_eff    = (burst_len_i == '0) ? LEN_W'(1) : burst_len_i;
    assign w_bcnt_inc   = {1'b0, r_bcnt} + (LEN_W+1)'(1);
    assign w_b_last     = (w_bcnt_inc == {1'b0, w_len_eff});
    // One extra bit keeps period_i==0 from ever matching.
    assign w_pcnt_inc   = {1'b0, r_pcnt} + (LEN_W+1)'(1);
    assign w_period_hit = (w_pcnt_inc == {1'b0, period_i});

    // Select whether the current symbol is to be corrupted
    always_comb begin
        w_trig = 1'b0;
        case (mode_i)
            c_MODE_RANDOM: w_trig = w_rand_hit;
            c_MODE_BURST: begin
                case (r_state)
                    ST_IDLE:  w_trig = w_rand_hit;
                    ST_BURST: w_trig = 1'b1;
                    default:  w_trig = 1'b0;
                endcase
            end
            c_MODE_PERIOD: w_trig = w_period_hit;
            default:       w_trig = 1'b0;
        endcase
    end

`ifdef VITERBI_CHAN_INJ_ROTATE_EN
    // ------------------------------------------------------------------
    // Single-lane rotation: pointer remembers the last flipped lane
    // ------------------------------------------------------------------
    localparam int c_PTR_W = (SYM_W > 1) ? $clog2(SYM_W) : 1;

    logic [c_PTR_W-1:0]   r_rot_ptr;
    logic [c_PTR_W-1:0]   w_rot_lane;
    logic                 w_rot_found;
    logic [2*SYM_W-1:0]   w_mask_dbl;
    logic [SYM_W-1:0]     w_mask_from_ptr;
    logic [SYM_W-1:0]     w_rot_flip;

    // Find the next enabled lane after the pointer, wrapping around
    always_comb begin
        w_mask_dbl      = {lane_mask_i, lane_mask_i};
        w_mask_from_ptr = SYM_W'(w_mask_dbl >> (int'(r_rot_ptr) + 1));
        w_rot_found     = 1'b0;
        w_rot_lane      = r_rot_ptr;
        // Descending scan so the nearest lane is the one that sticks.
        for (int j = SYM_W - 1; j >= 0; j--) begin
            if (w_mask_from_ptr[j]) begin
                w_rot_found = 1'b1;
                w_rot_lane  = c_PTR_W'((int'(r_rot_ptr) + 1 + j) % SYM_W);
            end
        end
        w_rot_flip = '0;
        for (int i = 0; i < SYM_W; i++) begin
            w_rot_flip[i] = w_rot_found && (c_PTR_W'(i) == w_rot_lane);
        end
        w_flip = w_trig ? w_rot_flip : '0;
    end

    // Advance the rotation pointer only when a lane is actually flipped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rot_ptr <= c_PTR_W'(SYM_W - 1);
        end else if (valid_i && w_trig && w_rot_found) begin
            r_rot_ptr <= w_rot_lane;
        end
    end
`else
    assign w_flip = w_trig ? lane_mask_i : '0;
`endif

    // ------------------------------------------------------------------
    // Counter increments
    // ------------------------------------------------------------------
    logic [CNT_W:0]   w_pop;
    logic [CNT_W-1:0] w_sym_ct_nxt;
    logic [CNT_W-1:0] w_inj_sym_nxt;
    logic [CNT_W-1:0] w_inj_bit_nxt;

    function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] a,
                                                   input logic [CNT_W:0]   inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + inc;
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Count flipped bits and form the saturated next counter values
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < SYM_W; i++) begin
            w_pop = w_pop + (CNT_W+1)'(w_flip[i]);
        end
        w_sym_ct_nxt  = f_sat_add(r_sym_ct, (CNT_W+1)'(1));
        w_inj_sym_nxt = f_sat_add(r_inj_sym_ct, (CNT_W+1)'(w_flip != '0));
        w_inj_bit_nxt = f_sat_add(r_inj_bit_ct, w_pop);
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Galois LFSR, one step per accepted symbol
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (valid_i) begin
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
        end
    end

    // Burst FSM: IDLE waits for a random hit, BURST flips, GAP rests
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bcnt  <= '0;
        end else if (mode_i != c_MODE_BURST) begin
            r_state <= ST_IDLE;
            r_bcnt  <= '0;
        end else if (valid_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rand_hit) begin
                        // A length-one burst is finished by its first symbol.
                        if (w_b_last) begin
                            r_state <= ST_GAP;
                            r_bcnt  <= '0;
                        end else begin
                            r_state <= ST_BURST;
                            r_bcnt  <= w_bcnt_inc[LEN_W-1:0];
                        end
                    end
                end
                ST_BURST: begin
                    if (w_b_last) begin
                        r_state <= ST_GAP;
                        r_bcnt  <= '0;
                    end else begin
                        r_bcnt  <= w_bcnt_inc[LEN_W-1:0];
                    end
                end
                ST_GAP: begin
                    if (w_b_last) begin
                        r_state <= ST_IDLE;
                        r_bcnt  <= '0;
                    end else begin
                        r_bcnt  <= w_bcnt_inc[LEN_W-1:0];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_bcnt  <= '0;
                end
            endcase
        end
    end

    // Period counter, wraps on each periodic hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (mode_i != c_MODE_PERIOD) begin
            r_pcnt <= '0;
        end else if (valid_i) begin
            r_pcnt <= w_period_hit ? '0 : w_pcnt_inc[LEN_W-1:0];
        end
    end

    // Output register: symbol and flip mask hold across invalid cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sym   <= '0;
            r_err   <= '0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_sym <= sym_i ^ w_flip;
                r_err <= w_flip;
            end
        end
    end

    // Statistics counters with sticky saturation flag; clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sym_ct     <= '0;
            r_inj_sym_ct <= '0;
            r_inj_bit_ct <= '0;
            r_sat        <= 1'b0;
        end else if (clr_i) begin
            r_sym_ct     <= '0;
            r_inj_sym_ct <= '0;
            r_inj_bit_ct <= '0;
            r_sat        <= 1'b0;
        end else if (valid_i) begin
            r_sym_ct     <= w_sym_ct_nxt;
            r_inj_sym_ct <= w_inj_sym_nxt;
            r_inj_bit_ct <= w_inj_bit_nxt;
            if ((&w_sym_ct_nxt) || (&w_inj_sym_nxt) || (&w_inj_bit_nxt)) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign valid_o      = r_valid;
    assign sym_o        = r_sym;
    assign err_inj_o    = r_err;
    assign sym_ct_o     = r_sym_ct;
    assign inj_sym_ct_o = r_inj_sym_ct;
    assign inj_bit_ct_o = r_inj_bit_ct;
    assign sat_o        = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_channel_sim.sv
`default_nettype none
// ============================================================================
// Module      : tb_viterbi_channel_sim
// Description : Self-checking bench for viterbi_channel_sim. A second
//               instance with 4-bit counters exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_channel_sim;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  sym_i = 2'b00;
    logic [1:0]  mode_i = 2'd0;
    logic [15:0] thresh_i = 16'h0;
    logic [1:0]  lane_mask_i = 2'b00;
    logic [3:0]  burst_len_i = 4'd0;
    logic [3:0]  period_i = 4'd0;
    logic        clr_i = 1'b0;

    logic        valid_o;
    logic [1:0]  sym_o;
    logic [1:0]  err_inj_o;
    logic [15:0] sym_ct_o;
    logic [15:0] inj_sym_ct_o;
    logic [15:0] inj_bit_ct_o;
    logic        sat_o;

    logic        o4_valid;
    logic [1:0]  o4_sym;
    logic [1:0]  o4_err;
    logic [3:0]  o4_sym_ct;
    logic [3:0]  o4_inj_sym_ct;
    logic [3:0]  o4_inj_bit_ct;
    logic        o4_sat;

    always #5 clk = ~clk;

    viterbi_channel_sim u_dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
        .thresh_i(thresh_i), .lane_mask_i(lane_mask_i), .burst_len_i(burst_len_i),
        .period_i(period_i), .clr_i(clr_i), .valid_o(valid_o), .sym_o(sym_o),
        .err_inj_o(err_inj_o), .sym_ct_o(sym_ct_o), .inj_sym_ct_o(inj_sym_ct_o),
        .inj_bit_ct_o(inj_bit_ct_o), .sat_o(sat_o)
    );

    viterbi_channel_sim #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
        .thresh_i(thresh_i), .lane_mask_i(lane_mask_i), .burst_len_i(burst_len_i),
        .period_i(period_i), .clr_i(clr_i), .valid_o(o4_valid), .sym_o(o4_sym),
        .err_inj_o(o4_err), .sym_ct_o(o4_sym_ct), .inj_sym_ct_o(o4_inj_sym_ct),
        .inj_bit_ct_o(o4_inj_bit_ct), .sat_o(o4_sat)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model (behavioural) ----------------
    logic [15:0] m_lfsr;
    int          m_burst_left, m_gap_left, m_pcnt, m_rot;
    logic        m_vo;
    logic [1:0]  m_so, m_eo;
    int          m_nsym, m_nis, m_nib;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lim(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_burst_left = 0; m_gap_left = 0; m_pcnt = 0; m_rot = 1;
        m_vo = 1'b0; m_so = 2'b00; m_eo = 2'b00;
        m_nsym = 0; m_nis = 0; m_nib = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_update();
        int         blen;
        bit         trig;
        logic [1:0] fl;
        blen = (burst_len_i == 4'd0) ? 1 : int'(burst_len_i);
        trig = 1'b0;
        fl   = 2'b00;
        if (valid_i) begin
            case (mode_i)
                2'd1: trig = (m_lfsr < thresh_i);
                2'd2: begin
                    if (m_burst_left > 0) begin
                        trig = 1'b1;
                        m_burst_left--;
                        if (m_burst_left == 0) m_gap_left = blen;
                    end else if (m_gap_left > 0) begin
                        m_gap_left--;
                    end else if (m_lfsr < thresh_i) begin
                        trig = 1'b1;
                        m_burst_left = blen - 1;
                        if (m_burst_left == 0) m_gap_left = blen;
                    end
                end
                2'd3: begin
                    if (m_pcnt + 1 == int'(period_i)) begin
                        trig = 1'b1;
                        m_pcnt = 0;
                    end else begin
                        m_pcnt = (m_pcnt + 1) % 16;
                    end
                end
                default: trig = 1'b0;
            endcase
            if (trig) begin
`ifdef VITERBI_CHAN_INJ_ROTATE_EN
                for (int k = 1; k <= 2; k++) begin
                    if (fl == 2'b00 && lane_mask_i[(m_rot + k) % 2]) begin
                        fl[(m_rot + k) % 2] = 1'b1;
                        m_rot = (m_rot + k) % 2;
                    end
                end
`else
                fl = lane_mask_i;
`endif
            end
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            m_so = sym_i ^ fl;
            m_eo = fl;
        end
        m_vo = valid_i;
        if (clr_i) begin
            m_nsym = 0; m_nis = 0; m_nib = 0;
        end else if (valid_i) begin
            m_nsym++;
            m_nis += (fl != 2'b00) ? 1 : 0;
            m_nib += $countones(fl);
        end
        if (mode_i != 2'd2) begin m_burst_left = 0; m_gap_left = 0; end
        if (mode_i != 2'd3) m_pcnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid_o"},   int'(valid_o),      int'(m_vo));
        chk({tag, ".sym_o"},     int'(sym_o),        int'(m_so));
        chk({tag, ".err_inj_o"}, int'(err_inj_o),    int'(m_eo));
        chk({tag, ".sym_ct"},    int'(sym_ct_o),     lim(m_nsym, 65535));
        chk({tag, ".inj_sym"},   int'(inj_sym_ct_o), lim(m_nis, 65535));
        chk({tag, ".inj_bit"},   int'(inj_bit_ct_o), lim(m_nib, 65535));
        chk({tag, ".sat"},       int'(sat_o),
            int'(m_nsym >= 65535 || m_nis >= 65535 || m_nib >= 65535));
        chk({tag, ".c4_sym_ct"}, int'(o4_sym_ct),     lim(m_nsym, 15));
        chk({tag, ".c4_inj_b"},  int'(o4_inj_bit_ct), lim(m_nib, 15));
        chk({tag, ".c4_sat"},    int'(o4_sat),
            int'(m_nsym >= 15 || m_nis >= 15 || m_nib >= 15));
    endtask

    task automatic tick(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic apply_reset();
        valid_i = 1'b0; clr_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_outputs("reset");
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  mask;
        logic [3:0]  blen;
        logic [3:0]  period;
        logic [15:0] thresh;
        logic [1:0]  sym;
        logic [1:0]  exp_sym;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t        tbl[28];
    logic [1:0]  rot_exp[4];
    logic [1:0]  run1[1024];
    int          ndiff, saved_ct, cnt_a;

    initial begin
        // Period 4, lane 1, all-zero input: every 4th symbol emerges as 2'b10.
        for (int i = 0; i < 16; i++)
            tbl[i] = '{2'd3, 2'b10, 4'd0, 4'd4, 16'h0000, 2'b00,
                       (i % 4 == 3) ? 2'b10 : 2'b00, (i % 4 == 3) ? 2'b10 : 2'b00};
        // Burst length 3, always-hit threshold: three flipped, three clean.
        for (int i = 0; i < 12; i++)
            tbl[16 + i] = '{2'd2, 2'b11, 4'd3, 4'd0, 16'hFFFF, 2'b00,
                            (i % 6 < 3) ? 2'b11 : 2'b00, (i % 6 < 3) ? 2'b11 : 2'b00};
`ifdef VITERBI_CHAN_INJ_ROTATE_EN
        rot_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        rot_exp = '{2'b11, 2'b11, 2'b11, 2'b11};
`endif

        apply_reset();

        // Table-driven period and burst sequences
        for (int i = 0; i < 28; i++) begin
            if (i == 0 || i == 16) apply_reset();
            valid_i     = 1'b1;
            mode_i      = tbl[i].mode;
            lane_mask_i = tbl[i].mask;
            burst_len_i = tbl[i].blen;
            period_i    = tbl[i].period;
            thresh_i    = tbl[i].thresh;
            sym_i       = tbl[i].sym;
            tick("tbl");
            chk($sformatf("tbl_sym[%0d]", i), int'(sym_o), int'(tbl[i].exp_sym));
            chk($sformatf("tbl_err[%0d]", i), int'(err_inj_o), int'(tbl[i].exp_err));
            if (i == 15) begin
                chk("period_inj_sym", int'(inj_sym_ct_o), 4);
                chk("period_inj_bit", int'(inj_bit_ct_o), 4);
            end
            if (i == 27) chk("burst_inj_bit", int'(inj_bit_ct_o), 12);
        end

        // Pass-through, then saturation of the 4-bit instance and clear
        apply_reset();
        mode_i = 2'd0; lane_mask_i = 2'b11; valid_i = 1'b1; sym_i = 2'b10;
        for (int i = 0; i < 300; i++) tick("pass");
        chk("pass_sym_o", int'(sym_o), 2);
        chk("pass_sym_ct", int'(sym_ct_o), 300);
        chk("pass_inj_sym", int'(inj_sym_ct_o), 0);
        chk("pass_inj_bit", int'(inj_bit_ct_o), 0);
        chk("sat4_sym_ct", int'(o4_sym_ct), 15);
        chk("sat4_sat", int'(o4_sat), 1);
        clr_i = 1'b1;
        tick("clr");
        clr_i = 1'b0;
        chk("clr_sym_ct", int'(sym_ct_o), 0);
        chk("clr4_sym_ct", int'(o4_sym_ct), 0);
        chk("clr4_sat", int'(o4_sat), 0);

        // Valid gaps freeze counters and LFSR
        tick("pre_gap");
        saved_ct = int'(sym_ct_o);
        valid_i = 1'b0;
        mode_i = 2'd1; thresh_i = 16'h8000;
        for (int i = 0; i < 5; i++) tick("gap");
        chk("gap_sym_ct", int'(sym_ct_o), saved_ct);
        valid_i = 1'b1;
        for (int i = 0; i < 20; i++) tick("post_gap");

        // Reset asserted mid-burst
        apply_reset();
        mode_i = 2'd2; thresh_i = 16'hFFFF; burst_len_i = 4'd5; lane_mask_i = 2'b11;
        valid_i = 1'b1; sym_i = 2'b01;
        tick("burst_a");
        tick("burst_b");
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst_err", int'(err_inj_o), 0);
        #2;
        rst = 1'b0;
        thresh_i = 16'h0000;
        tick("after_rst");
        chk("after_rst_idle", int'(err_inj_o), 0);

        // Lane rotation with period 1
        apply_reset();
        mode_i = 2'd3; period_i = 4'd1; lane_mask_i = 2'b11; sym_i = 2'b00; valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick("rot");
            chk($sformatf("rot_err[%0d]", i), int'(err_inj_o), int'(rot_exp[i]));
        end

        // Random-mode reproducibility across reset
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            mode_i = 2'd1; thresh_i = 16'h4000; lane_mask_i = 2'b01; valid_i = 1'b1;
            ndiff = 0;
            for (int i = 0; i < 1024; i++) begin
                sym_i = 2'($urandom_range(0, 3));
                tick("repro");
                if (pass == 0) run1[i] = err_inj_o;
                else if (run1[i] != err_inj_o) ndiff++;
            end
            cnt_a = int'(inj_sym_ct_o);
            chk("repro_rate_in_range", int'(cnt_a >= 208 && cnt_a <= 304), 1);
        end
        chk("repro_diff", ndiff, 0);

        // Randomized segments against the model
        apply_reset();
        for (int seg = 0; seg < 8; seg++) begin
            valid_i = 1'b0; mode_i = 2'd0; clr_i = 1'b0;
            tick("seg_sep");
            mode_i      = 2'($urandom_range(0, 3));
            lane_mask_i = 2'($urandom_range(0, 3));
            burst_len_i = 4'($urandom_range(0, 15));
            period_i    = 4'($urandom_range(0, 15));
            thresh_i    = 16'($urandom_range(0, 65535));
            for (int i = 0; i < 400; i++) begin
                valid_i = ($urandom_range(0, 9) < 8);
                sym_i   = 2'($urandom_range(0, 3));
                clr_i   = ($urandom_range(0, 99) == 0);
                tick("rand");
            end
        end
        clr_i = 1'b0; valid_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
